// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported 16-bit memory between the fetch port and the data port.
// Define MEM_ARB_FAIR_EN to alternate grants when both ports request; otherwise data has strict priority.
module mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    // Handshake: a requester holds req (and its address/data) stable until it sees a
    // one-cycle ack; the ack cycle is never a sample point, so req may drop the cycle after.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT = LATENCY[3:0];

    state_t      state;
    logic [3:0]  cnt;
    logic        win_d;
    logic        pick_d;

`ifdef MEM_ARB_FAIR_EN
    logic        fav_i;
    logic        both_pend;

    // Data wins unless fetch is also pending and the pointer currently favours fetch.
    assign pick_d = d_req && !(i_req && fav_i);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            win_d     <= 1'b0;
            i_ack     <= 1'b0;
            i_rdata   <= 16'h0;
            d_ack     <= 1'b0;
            d_rdata   <= 16'h0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0;
            mem_wdata <= 16'h0;
`ifdef MEM_ARB_FAIR_EN
            fav_i     <= 1'b0;
            both_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        win_d     <= pick_d;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_d & d_we;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_wdata <= (pick_d && d_we) ? d_wdata : 16'h0;
`ifdef MEM_ARB_FAIR_EN
                        both_pend <= i_req && d_req;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= LAT;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                        if (win_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_we ? 16'h0 : mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    i_ack     <= 1'b0;
                    i_rdata   <= 16'h0;
                    d_ack     <= 1'b0;
                    d_rdata   <= 16'h0;
                    mem_we    <= 1'b0;
                    mem_addr  <= 16'h0;
                    mem_wdata <= 16'h0;
`ifdef MEM_ARB_FAIR_EN
                    // Only a contested grant moves the pointer, toward the port that lost.
                    if (both_pend) fav_i <= win_d;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LATENCY 2, 1, 15) sharing one memory image,
// directed vector table, contention sequences, reset abort and randomized rounds.
module tb_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [2:0]       i_req, i_ack, d_req, d_we, d_ack, mem_en, mem_we;
    logic [2:0][15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [2:0][15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   pref_i   = 1'b0;
    logic [24:0] exp_q[$];

    typedef struct {
        bit          port_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        if (a == 16'h0010) return 16'hB123;
        return 16'((a * 40503) ^ 23130);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [15:0] rd_addr = 16'h0;
        int          dly     = 0;
        logic        pend    = 1'b0;

        mem_arbiter #(.LATENCY(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req[g]),
            .i_addr    (i_addr[g]),
            .i_rdata   (i_rdata[g]),
            .i_ack     (i_ack[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_rdata   (d_rdata[g]),
            .d_ack     (d_ack[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        // Read data becomes valid LAT edges after the edge that samples mem_en; garbage before.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                pend    <= 1'b1;
                rd_addr <= mem_addr[g];
                dly     <= LAT - 1;
            end else if (dly > 0) begin
                dly <= dly - 1;
            end
        end
        assign mem_rdata[g] = (pend && dly == 0) ? mem[rd_addr] : 16'hDEAD;
    end

    // Memory image; only instance 0 ever writes.
    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = init_val(a);
        forever begin
            @(posedge clk);
            if (mem_en[0] && mem_we[0]) mem[mem_addr[0]] = mem_wdata[0];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic bit outs_zero(input int k);
        return i_ack[k] == 1'b0 && d_ack[k] == 1'b0 && mem_en[k] == 1'b0 && mem_we[k] == 1'b0 &&
               mem_addr[k] == 16'h0 && mem_wdata[k] == 16'h0 && i_rdata[k] == 16'h0 &&
               d_rdata[k] == 16'h0;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        i_req = '0; d_req = '0; d_we = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        pref_i = 1'b0;
    endtask

    task automatic do_txn(input int k, input bit port_d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata,
                          input string name);
        int          lat = lat_of(k);
        int          cyc = 0;
        int          en_cnt = 0;
        bit          acked = 1'b0;
        bit          addr_ok = 1'b1;
        bit          we_ok = 1'b1;
        bit          other_ack = 1'b0;
        logic [15:0] got = 16'hxxxx;
        if (port_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        while (!acked && cyc < lat + 10) begin
            @(negedge clk);
            cyc++;
            if (mem_en[k]) begin
                en_cnt++;
                if (mem_we[k] !== (port_d & we)) we_ok = 1'b0;
                if (port_d && we && mem_wdata[k] !== wdata) we_ok = 1'b0;
            end
            if (mem_addr[k] !== addr) addr_ok = 1'b0;
            if (port_d ? i_ack[k] : d_ack[k]) other_ack = 1'b1;
            if (port_d ? d_ack[k] : i_ack[k]) begin
                acked = 1'b1;
                got   = port_d ? d_rdata[k] : i_rdata[k];
            end
        end
        d_req[k] = 1'b0;
        i_req[k] = 1'b0;
        check($sformatf("%s latency", name), 32'(cyc), 32'(lat + 2));
        check($sformatf("%s rdata", name), {16'h0, got}, {16'h0, exp_rdata});
        check($sformatf("%s mem_en pulses", name), 32'(en_cnt), 32'd1);
        check($sformatf("%s mem_we/wdata", name), {31'h0, we_ok}, 32'd1);
        check($sformatf("%s mem_addr held", name), {31'h0, addr_ok}, 32'd1);
        check($sformatf("%s other ack", name), {31'h0, other_ack}, 32'd0);
        @(negedge clk);
        check($sformatf("%s idle outputs zero", name), {31'h0, outs_zero(k)}, 32'd1);
    endtask

    // Runs instance 0 until every queued ack {cycle, is_data, rdata} has been seen.
    task automatic run_round(input string name);
        int          cyc = 0;
        bit          dual = 1'b0;
        logic [24:0] exp, got;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (i_ack[0] && d_ack[0]) dual = 1'b1;
            if (d_ack[0]) begin
                got = {cyc[7:0], 1'b1, d_rdata[0]};
                d_req[0] = 1'b0;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h0;
                check($sformatf("%s d ack {cyc,port,data}", name), 32'(got), 32'(exp));
            end
            if (i_ack[0]) begin
                got = {cyc[7:0], 1'b0, i_rdata[0]};
                i_req[0] = 1'b0;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h0;
                check($sformatf("%s i ack {cyc,port,data}", name), 32'(got), 32'(exp));
            end
        end
        check($sformatf("%s acks outstanding", name), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        i_req[0] = 1'b0;
        d_req[0] = 1'b0;
        check($sformatf("%s simultaneous acks", name), {31'h0, dual}, 32'd0);
        @(negedge clk);
        check($sformatf("%s idle outputs zero", name), {31'h0, outs_zero(0)}, 32'd1);
    endtask

    initial begin
        int          cyc;
        int          n_acks;
        bit          data_ok;
        logic [3:0]  seq;
        int          mode;
        bit          has_i, has_d, first_d, we;
        logic [15:0] ia, da, wd, rd;

        i_req = '0; d_req = '0; d_we = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(a);

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hB123};
        vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'hA5A5, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hA5A5};
        vecs[3] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'hA5A5};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h1234};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, init_val(0)};

        reset_dut();
        for (int k = 0; k < 3; k++)
            check($sformatf("reset outputs zero inst%0d", k), {31'h0, outs_zero(k)}, 32'd1);

        do_txn(1, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hB123, "lat1 fetch");
        do_txn(2, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hB123, "lat15 fetch");

        for (int v = 0; v < 7; v++) begin
            do_txn(0, vecs[v].port_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp_rdata, $sformatf("vec%0d", v));
            if (vecs[v].port_d && vecs[v].we) ref_mem[vecs[v].addr] = vecs[v].wdata;
        end

        // Both requests held: data goes first, fetch follows after a full access.
        reset_dut();
        i_req[0] = 1'b1; i_addr[0] = 16'h0010;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0100;
        exp_q.push_back({8'd4, 1'b1, 16'hA5A5});
        exp_q.push_back({8'd9, 1'b0, 16'hB123});
        run_round("both pending");

        // Both held continuously across four accesses.
        reset_dut();
        i_req[0] = 1'b1; i_addr[0] = 16'h0010;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0100;
        cyc = 0; n_acks = 0; seq = 4'h0; data_ok = 1'b1;
        while (n_acks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (d_ack[0] || i_ack[0]) begin
                n_acks++;
                seq = {seq[2:0], d_ack[0]};
                if (d_ack[0] && d_rdata[0] !== 16'hA5A5) data_ok = 1'b0;
                if (i_ack[0] && i_rdata[0] !== 16'hB123) data_ok = 1'b0;
            end
        end
        i_req[0] = 1'b0;
        d_req[0] = 1'b0;
        check("contention ack count", 32'(n_acks), 32'd4);
        check("contention ack order (1=data)", {28'h0, seq}, FAIR ? 32'hA : 32'hF);
        check("contention rdata", {31'h0, data_ok}, 32'd1);
        @(negedge clk);
        check("contention idle outputs zero", {31'h0, outs_zero(0)}, 32'd1);

        // Randomized rounds against the reference model.
        reset_dut();
        for (int r = 0; r < 30; r++) begin
            mode  = $urandom_range(0, 2);
            has_i = (mode != 1);
            has_d = (mode != 0);
            da    = 16'h0300 + 16'($urandom_range(0, 3));
            ia    = $urandom_range(0, 1) ? 16'h0300 + 16'($urandom_range(0, 3)) : 16'($urandom);
            we    = 1'($urandom_range(0, 1));
            wd    = 16'($urandom);
            first_d = has_d && (!has_i || !FAIR || !pref_i);
            if (has_i && has_d && FAIR) pref_i = first_d;
            for (int slot = 0; slot < 2; slot++) begin
                bit serve_d = (slot == 0) ? first_d : !first_d;
                bit present = serve_d ? has_d : has_i;
                int t = (slot == 0) ? 4 : 9;
                if (present) begin
                    if (serve_d) begin
                        rd = we ? 16'h0 : ref_mem[da];
                        if (we) ref_mem[da] = wd;
                        exp_q.push_back({8'(t), 1'b1, rd});
                    end else begin
                        exp_q.push_back({8'(t), 1'b0, ref_mem[ia]});
                    end
                end
            end
            i_req[0] = has_i; i_addr[0] = ia;
            d_req[0] = has_d; d_we[0] = we; d_addr[0] = da; d_wdata[0] = wd;
            run_round($sformatf("rand%0d", r));
        end

        // Reset during WAIT of a load: aborted with no ack, then the held request is re-served.
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0100;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-wait outputs zero", {31'h0, outs_zero(0)}, 32'd1);
        @(negedge clk);
        check("reset held, no strobe", {31'h0, outs_zero(0)}, 32'd1);
        rst    = 1'b0;
        pref_i = 1'b0;
        exp_q.push_back({8'd4, 1'b1, 16'hA5A5});
        run_round("reissue after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-ported unified 16-bit memory between the instruction-fetch port and the data port (LW/SW) of the WISC CPU. It sits between the fetch stage and the memory stage on one side and the memory macro on the other. It grants one access at a time, drives the memory for a fixed read latency, and returns a one-cycle acknowledge to the winning requester. The pipeline stalls on the absence of `i_ack`/`d_ack`.

## Interface
Parameters:
- `LATENCY`, default 2: memory cycles from the `mem_en` sample edge to valid `mem_rdata`. Legal range is 1–15.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request. Held high until `i_ack`.
- `i_addr` in 16: fetch address. Stable while `i_req` is high.
- `i_rdata` out 16: fetched instruction. Valid only while `i_ack` is high.
- `i_ack` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request. Held high until `d_ack`.
- `d_we` in 1: 1 = store (SW), 0 = load (LW). Stable while `d_req` is high.
- `d_addr` in 16: data address.
- `d_wdata` in 16: store data.
- `d_rdata` out 16: load data. Valid while `d_ack` is high; 0 for stores.
- `d_ack` out 1: one-cycle completion pulse for data.
- `mem_en` out 1: one-cycle memory strobe.
- `mem_we` out 1: memory write enable. Qualified by `mem_en`.
- `mem_addr` out 16: memory address. Held for the whole transaction.
- `mem_wdata` out 16: memory write data. Held for the whole transaction.
- `mem_rdata` in 16: memory read data.

## Operation
- FSM states:
  - IDLE: on a rising edge with any request, latch the winner, its address, we and wdata, then go to ISSUE. With no request, stay in IDLE.
  - ISSUE: `mem_en`=1 for exactly this cycle. Counter loads `LATENCY`. Go to WAIT.
  - WAIT: counter decrements each cycle. When the counter reaches 1, capture `mem_rdata` at that edge and go to DONE.
  - DONE: the winner's ack=1 and its rdata is driven from the capture register. Go to IDLE. Requests are not sampled in DONE, so a still-high `req` of the acked requester is never re-granted.
- Arbitration when both requests are high in IDLE: data wins (strict priority). Rationale: the data access belongs to an older instruction, so this avoids deadlock.
- The fetch port has no write path. Fetch is always a read with `mem_we`=0.
- A store returns `d_rdata`=0. The memory is written on the ISSUE edge.
- `mem_addr`, `mem_we` and `mem_wdata` hold the latched values from ISSUE through DONE. They are 0 in IDLE.
- The losing request stays pending with no side effects and is granted on the next IDLE sample.
- `i_ack` and `d_ack` are never high in the same cycle.

## Timing
- Request sampled at edge E0. ISSUE is the cycle after E0, DONE is cycle LATENCY+2 after E0, and IDLE follows.
- Request-to-ack latency is LATENCY+2 cycles. Back-to-back throughput is one access per LATENCY+3 cycles.
- A requester may drop `req` in the cycle after its ack. The arbiter next samples in the IDLE cycle following DONE.
- Reset values: state IDLE, all outputs 0, counter 0, fairness pointer favours data.
- Reset asserted mid-transaction aborts it with no ack. Requesters must re-issue.
- `mem_en` must not be asserted during reset. A write already issued at ISSUE is not undone.
- LATENCY=1: WAIT lasts one cycle. The counter never wraps; the minimum is a 1-cycle WAIT.

## Configuration
- `MEM_ARB_FAIR_EN` defined: when both requests are high in IDLE, the grant alternates. A 1-bit pointer flips to the other port after every completed DONE whose winner was chosen while both were pending. Fetch can never be starved for more than one data access.
- `MEM_ARB_FAIR_EN` undefined: strict data priority as described in Operation. The pointer logic is absent.

## Test plan
- Single fetch, LATENCY=2, `i_addr`=0x0010, memory[0x0010]=0xB123:
  - `i_ack` is high exactly 4 cycles after the sample edge, with `i_rdata`=0xB123.
  - `mem_en` is high for one cycle with `mem_we`=0.
- Store then load, `d_addr`=0x0100, `d_wdata`=0xA5A5:
  - Store: `mem_we`=1 in ISSUE and `d_ack` returns `d_rdata`=0.
  - The following load to 0x0100 returns 0xA5A5.
- Simultaneous `i_req`/`d_req` held high, no macro:
  - Data is acked first, then fetch.
  - With `d_req` reasserted every IDLE, `i_ack` never appears.
- Same stimulus with `MEM_ARB_FAIR_EN`: the ack order is d, i, d, i.
- `rst` pulsed during WAIT of a load: no ack, all outputs 0 the cycle after, and the FSM is in IDLE. A re-issued load completes normally.
- LATENCY=1 and LATENCY=15: ack lands at 3 and 17 cycles respectively. `mem_addr` is held constant through the transaction.
